// File: rtl/rv32i_pkg.sv
// Shared rv32i encodings: IR decode fields, ALU operations and the multicycle
// controller's state and datapath-select encodings.
package rv32i_pkg;

   typedef enum logic [6:0] {
      OP_LOAD  = 7'd3,
      OP_ITYPE = 7'd19,
      OP_STORE = 7'd35,
      OP_RTYPE = 7'd51
   } instr_type_t;

   typedef enum logic [2:0] {
      F_ADD  = 3'd0,
      F_SLL  = 3'd1,
      F_SLT  = 3'd2,
      F_SLTU = 3'd3,
      F_XOR  = 3'd4,
      F_SR   = 3'd5,
      F_OR   = 3'd6,
      F_AND  = 3'd7
   } func_code_t;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_SLL = 4'd2,
      ALU_XOR = 4'd3,
      ALU_SRL = 4'd4,
      ALU_SRA = 4'd5,
      ALU_OR  = 4'd6,
      ALU_AND = 4'd7
   } alu_op_t;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_LOADWB,
      S_MEMWR,
      S_EXEC_R,
      S_EXEC_I,
      S_ALUWB,
      S_TRAP
   } mc_state_t;

   typedef enum logic {
      CLS_ADD,
      CLS_FUNC
   } alu_class_t;

   localparam logic       ADR_PC      = 1'b0;
   localparam logic       ADR_ALUOUT  = 1'b1;

   localparam logic [1:0] SRCA_PC     = 2'd0;
   localparam logic [1:0] SRCA_OLDPC  = 2'd1;
   localparam logic [1:0] SRCA_RS1    = 2'd2;

   localparam logic [1:0] SRCB_RS2    = 2'd0;
   localparam logic [1:0] SRCB_IMM    = 2'd1;
   localparam logic [1:0] SRCB_FOUR   = 2'd2;

   localparam logic [1:0] RES_ALUOUT  = 2'd0;
   localparam logic [1:0] RES_MEMDATA = 2'd1;
   localparam logic [1:0] RES_ALU     = 2'd2;

   localparam logic       IMM_I       = 1'b0;
   localparam logic       IMM_S       = 1'b1;

   // funct3 codes 2 and 3 have no matching ALU operation, so they are decoded as illegal.
   function automatic logic func_supported(input logic [2:0] f);
      return !((f == F_SLT) || (f == F_SLTU));
   endfunction

endpackage

// File: rtl/rv32i_alu_decoder.sv
// Combinational ALU operation select: fixed ADD for address/PC arithmetic,
// funct3/funct7 decode for R- and I-type execute steps.
module rv32i_alu_decoder
   import rv32i_pkg::*;
(
   input  alu_class_t  alu_class,
   input  logic        is_rtype,
   input  logic [2:0]  func_code,
   input  logic        funct7b5,
   output logic [3:0]  alu_ctrl
);

   // funct7b5 selects SUB only for R-type; for I-type ADDI it is immediate bits.
   always_comb begin
      alu_ctrl = ALU_ADD;
      if (alu_class == CLS_FUNC) begin
         case (func_code)
            F_ADD:   alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            F_SLL:   alu_ctrl = ALU_SLL;
            F_XOR:   alu_ctrl = ALU_XOR;
            F_SR:    alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
            F_OR:    alu_ctrl = ALU_OR;
            F_AND:   alu_ctrl = ALU_AND;
            default: alu_ctrl = ALU_ADD;
         endcase
      end
   end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Main sequencing FSM for the shared-ALU, single-memory-port rv32i multicycle
// datapath, including the memory wait counter and timeout pulse.
module rv32i_multicycle_ctrl
   import rv32i_pkg::*;
#(
   parameter int MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  instr_type,
   input  logic [2:0]  func_code,
   input  logic        funct7b5,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        adr_src,
   output logic        pc_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        imm_src,
   output logic [1:0]  result_src,
   output logic [3:0]  alu_ctrl,
   output logic        retire,
   output logic        illegal,
   output logic        mem_timeout
);

   localparam int             CNT_W     = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

   mc_state_t         state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   alu_class_t        alu_class;
   logic              is_rtype;
   logic              is_store;

   assign is_store = (instr_type == OP_STORE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      adr_src     = ADR_PC;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      imm_src     = IMM_I;
      result_src  = RES_ALUOUT;
      alu_class   = CLS_ADD;
      is_rtype    = 1'b0;
      retire      = 1'b0;
      illegal     = 1'b0;
      mem_timeout = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            adr_src    = ADR_PC;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            // oldPC+imm is computed here for free; nothing consumes it yet.
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = is_store ? IMM_S : IMM_I;
            case (instr_type)
               OP_LOAD,
               OP_STORE: state_d = S_MEMADR;
               OP_RTYPE: state_d = func_supported(func_code) ? S_EXEC_R : S_TRAP;
               OP_ITYPE: state_d = func_supported(func_code) ? S_EXEC_I : S_TRAP;
               default:  state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = is_store ? IMM_S : IMM_I;
            state_d   = is_store ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            adr_src = ADR_ALUOUT;
            if (mem_ready) begin
               state_d = S_LOADWB;
            end
         end
         S_LOADWB: begin
            result_src = RES_MEMDATA;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = ADR_ALUOUT;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC_R: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_class = CLS_FUNC;
            is_rtype  = 1'b1;
            state_d   = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_class = CLS_FUNC;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_TRAP: begin
            illegal = 1'b1;
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Wait counter restarts for every new state so each access is timed alone.
      if (state_d != state_q) begin
         wait_cnt_d = '0;
      end else if (mem_req && !mem_ready && (wait_cnt_q != WAIT_MAX)) begin
         wait_cnt_d  = wait_cnt_q + 1'b1;
         mem_timeout = (wait_cnt_q == WAIT_LAST);
      end

      // Reset suppresses every strobe immediately so an in-flight access cannot complete.
      if (rst) begin
         mem_req     = 1'b0;
         mem_we      = 1'b0;
         adr_src     = ADR_PC;
         pc_write    = 1'b0;
         ir_write    = 1'b0;
         reg_write   = 1'b0;
         alu_src_a   = SRCA_PC;
         alu_src_b   = SRCB_RS2;
         imm_src     = IMM_I;
         result_src  = RES_ALUOUT;
         alu_class   = CLS_ADD;
         is_rtype    = 1'b0;
         retire      = 1'b0;
         illegal     = 1'b0;
         mem_timeout = 1'b0;
      end
   end

   rv32i_alu_decoder u_alu_decoder (
      .alu_class (alu_class),
      .is_rtype  (is_rtype),
      .func_code (func_code),
      .funct7b5  (funct7b5),
      .alu_ctrl  (alu_ctrl)
   );

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Scoreboard bench for rv32i_multicycle_ctrl: directed per-cycle vectors push
// hand-derived expected outputs; a negedge monitor pops and compares them.
module tb_rv32i_multicycle_ctrl;
   import rv32i_pkg::*;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       adr_src;
      logic       pc_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic       imm_src;
      logic [1:0] res;
      logic [3:0] alu;
      logic       retire;
      logic       illegal;
      logic       timeout;
   } exp_t;

   typedef struct {
      exp_t  e;
      string name;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] instr_type = 7'd0;
   logic [2:0] func_code = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, adr_src, pc_write, ir_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic       imm_src, retire, illegal, mem_timeout;
   logic [3:0] alu_ctrl;
   exp_t       act;
   sb_t        sb_q[$];
   int         n_vec = 0;
   int         n_miss = 0;

   rv32i_multicycle_ctrl #(.MAX_WAIT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_type  (instr_type),
      .func_code   (func_code),
      .funct7b5    (funct7b5),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .adr_src     (adr_src),
      .pc_write    (pc_write),
      .ir_write    (ir_write),
      .reg_write   (reg_write),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .imm_src     (imm_src),
      .result_src  (result_src),
      .alu_ctrl    (alu_ctrl),
      .retire      (retire),
      .illegal     (illegal),
      .mem_timeout (mem_timeout)
   );

   always #5 clk = ~clk;

   assign act = {mem_req, mem_we, adr_src, pc_write, ir_write, reg_write,
                 alu_src_a, alu_src_b, imm_src, result_src, alu_ctrl,
                 retire, illegal, mem_timeout};

   // Expected output vectors per FSM step, written from the control table.
   function automatic exp_t e_idle();
      exp_t e = '0;
      e.alu = ALU_ADD;
      return e;
   endfunction

   function automatic exp_t e_fetch(input logic rdy, input logic to);
      exp_t e = e_idle();
      e.mem_req = 1'b1; e.src_b = 2'd2; e.res = 2'd2;
      e.ir_write = rdy; e.pc_write = rdy; e.timeout = to;
      return e;
   endfunction

   function automatic exp_t e_decode(input logic st);
      exp_t e = e_idle();
      e.src_a = 2'd1; e.src_b = 2'd1; e.imm_src = st;
      return e;
   endfunction

   function automatic exp_t e_memadr(input logic st);
      exp_t e = e_idle();
      e.src_a = 2'd2; e.src_b = 2'd1; e.imm_src = st;
      return e;
   endfunction

   function automatic exp_t e_memrd(input logic to);
      exp_t e = e_idle();
      e.mem_req = 1'b1; e.adr_src = 1'b1; e.timeout = to;
      return e;
   endfunction

   function automatic exp_t e_loadwb();
      exp_t e = e_idle();
      e.res = 2'd1; e.reg_write = 1'b1; e.retire = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_memwr(input logic rdy);
      exp_t e = e_idle();
      e.mem_req = 1'b1; e.mem_we = 1'b1; e.adr_src = 1'b1; e.retire = rdy;
      return e;
   endfunction

   function automatic exp_t e_exec(input logic r, input logic [3:0] op);
      exp_t e = e_idle();
      e.src_a = 2'd2; e.src_b = r ? 2'd0 : 2'd1; e.alu = op;
      return e;
   endfunction

   function automatic exp_t e_aluwb();
      exp_t e = e_idle();
      e.res = 2'd0; e.reg_write = 1'b1; e.retire = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_trap();
      exp_t e = e_idle();
      e.illegal = 1'b1;
      return e;
   endfunction

   task automatic applyStimulus(input string name, input logic r, input logic [6:0] it,
                                input logic [2:0] f, input logic b5, input logic rdy,
                                input exp_t e);
      sb_t s;
      @(posedge clk);
      #1;
      rst = r; instr_type = it; func_code = f; funct7b5 = b5; mem_ready = rdy;
      s.e = e; s.name = name;
      sb_q.push_back(s);
   endtask

   task automatic checkOutput(input sb_t s);
      n_vec++;
      if (act !== s.e) begin
         n_miss++;
         $display("[TB] FAIL %s: got %05h want %05h", s.name, act, s.e);
      end
   endtask

   task automatic run_alu(input string name, input logic [6:0] it, input logic [2:0] f,
                          input logic b5, input logic [3:0] op);
      logic r = (it == 7'd51);
      applyStimulus({name, "_fetch"},  1'b0, it, f, b5, 1'b1, e_fetch(1'b1, 1'b0));
      applyStimulus({name, "_decode"}, 1'b0, it, f, b5, 1'b1, e_decode(1'b0));
      applyStimulus({name, "_exec"},   1'b0, it, f, b5, 1'b1, e_exec(r, op));
      applyStimulus({name, "_wb"},     1'b0, it, f, b5, 1'b1, e_aluwb());
   endtask

   task automatic run_trap(input string name, input logic [6:0] it, input logic [2:0] f);
      applyStimulus({name, "_fetch"},  1'b0, it, f, 1'b0, 1'b1, e_fetch(1'b1, 1'b0));
      applyStimulus({name, "_decode"}, 1'b0, it, f, 1'b0, 1'b1, e_decode(1'b0));
      applyStimulus({name, "_trap"},   1'b0, it, f, 1'b0, 1'b1, e_trap());
   endtask

   // Monitor: every sampled cycle with a pending expectation is compared.
   initial begin
      sb_t s;
      forever begin
         @(negedge clk);
         if (sb_q.size() != 0) begin
            s = sb_q.pop_front();
            checkOutput(s);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyStimulus("reset0", 1'b1, 7'd0, 3'd0, 1'b0, 1'b1, e_idle());
      applyStimulus("reset1", 1'b1, 7'd0, 3'd0, 1'b0, 1'b1, e_idle());

      run_alu("add",  7'd51, 3'd0, 1'b0, ALU_ADD);
      run_alu("sub",  7'd51, 3'd0, 1'b1, ALU_SUB);
      run_alu("addi", 7'd19, 3'd0, 1'b1, ALU_ADD);
      run_alu("srai", 7'd19, 3'd5, 1'b1, ALU_SRA);
      run_alu("srl",  7'd51, 3'd5, 1'b0, ALU_SRL);
      run_alu("xor",  7'd51, 3'd4, 1'b0, ALU_XOR);
      run_alu("sll",  7'd51, 3'd1, 1'b0, ALU_SLL);
      run_alu("ori",  7'd19, 3'd6, 1'b0, ALU_OR);
      run_alu("andi", 7'd19, 3'd7, 1'b1, ALU_AND);

      applyStimulus("ld_fetch",  1'b0, 7'd3, 3'd2, 1'b0, 1'b1, e_fetch(1'b1, 1'b0));
      applyStimulus("ld_decode", 1'b0, 7'd3, 3'd2, 1'b0, 1'b1, e_decode(1'b0));
      applyStimulus("ld_adr",    1'b0, 7'd3, 3'd2, 1'b0, 1'b1, e_memadr(1'b0));
      for (int i = 0; i < 3; i++)
         applyStimulus("ld_wait", 1'b0, 7'd3, 3'd2, 1'b0, 1'b0, e_memrd(1'b0));
      applyStimulus("ld_rd",     1'b0, 7'd3, 3'd2, 1'b0, 1'b1, e_memrd(1'b0));
      applyStimulus("ld_wb",     1'b0, 7'd3, 3'd2, 1'b0, 1'b1, e_loadwb());

      applyStimulus("st_fetch",  1'b0, 7'd35, 3'd2, 1'b0, 1'b1, e_fetch(1'b1, 1'b0));
      applyStimulus("st_decode", 1'b0, 7'd35, 3'd2, 1'b0, 1'b1, e_decode(1'b1));
      applyStimulus("st_adr",    1'b0, 7'd35, 3'd2, 1'b0, 1'b1, e_memadr(1'b1));
      applyStimulus("st_wait",   1'b0, 7'd35, 3'd2, 1'b0, 1'b0, e_memwr(1'b0));
      applyStimulus("st_wr",     1'b0, 7'd35, 3'd2, 1'b0, 1'b1, e_memwr(1'b1));

      run_trap("bad_op", 7'h7F, 3'd0);
      run_trap("slt_r",  7'd51, 3'd2);
      run_trap("sltu_i", 7'd19, 3'd3);

      for (int i = 1; i <= 20; i++)
         applyStimulus("to_fetch", 1'b0, 7'd51, 3'd0, 1'b0, 1'b0, e_fetch(1'b0, i == 16));
      applyStimulus("to_rst", 1'b1, 7'd51, 3'd0, 1'b0, 1'b0, e_idle());
      for (int i = 1; i <= 17; i++)
         applyStimulus("to_again", 1'b0, 7'd51, 3'd0, 1'b0, 1'b0, e_fetch(1'b0, i == 16));
      run_alu("add2", 7'd51, 3'd0, 1'b0, ALU_ADD);

      for (int i = 0; i < 10; i++)
         applyStimulus("clr_fetch", 1'b0, 7'd3, 3'd0, 1'b0, 1'b0, e_fetch(1'b0, 1'b0));
      applyStimulus("clr_fetch", 1'b0, 7'd3, 3'd0, 1'b0, 1'b1, e_fetch(1'b1, 1'b0));
      applyStimulus("clr_decode", 1'b0, 7'd3, 3'd0, 1'b0, 1'b1, e_decode(1'b0));
      applyStimulus("clr_adr",    1'b0, 7'd3, 3'd0, 1'b0, 1'b1, e_memadr(1'b0));
      for (int i = 0; i < 10; i++)
         applyStimulus("clr_wait", 1'b0, 7'd3, 3'd0, 1'b0, 1'b0, e_memrd(1'b0));
      applyStimulus("clr_rd",     1'b0, 7'd3, 3'd0, 1'b0, 1'b1, e_memrd(1'b0));
      applyStimulus("clr_wb",     1'b0, 7'd3, 3'd0, 1'b0, 1'b1, e_loadwb());

      applyStimulus("ra_fetch",  1'b0, 7'd35, 3'd0, 1'b0, 1'b1, e_fetch(1'b1, 1'b0));
      applyStimulus("ra_decode", 1'b0, 7'd35, 3'd0, 1'b0, 1'b1, e_decode(1'b1));
      applyStimulus("ra_adr",    1'b0, 7'd35, 3'd0, 1'b0, 1'b1, e_memadr(1'b1));
      applyStimulus("ra_wait",   1'b0, 7'd35, 3'd0, 1'b0, 1'b0, e_memwr(1'b0));
      applyStimulus("ra_rst",    1'b1, 7'd35, 3'd0, 1'b0, 1'b1, e_idle());
      applyStimulus("ra_fetch2", 1'b0, 7'd35, 3'd0, 1'b0, 1'b0, e_fetch(1'b0, 1'b0));
      applyStimulus("ra_fetch3", 1'b0, 7'd35, 3'd0, 1'b0, 1'b1, e_fetch(1'b1, 1'b0));

      @(posedge clk);
      @(negedge clk);
      #1;
      n_vec++;
      if (sb_q.size() != 0) begin
         n_miss++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
